// File: rtl/countdown_bcd_timer.sv
// countdown_bcd_timer: four-digit MM:SS BCD countdown timer with preset load,
// start/pause/resume and a one-cycle done pulse when the count reaches 00:00.
//
// Ports:
//   i_clk          system clock, rising-edge active
//   i_rst_n        asynchronous active-low reset
//   i_enable       global clock enable; low freezes every register (done drops)
//   i_load         load i_load_digits (clamped to valid BCD) as new preset
//   i_load_digits  preset {min tens, min units, sec tens, sec units}
//   i_start        start or resume the countdown
//   i_stop         pause the countdown
//   o_digits       current value, same nibble order as i_load_digits
//   o_running      high while counting
//   o_expired      high after reaching 00:00 until the next load
//   o_done         one-cycle pulse registered with the first 00:00
module countdown_bcd_timer #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_load,
    input  logic [15:0] i_load_digits,
    input  logic        i_start,
    input  logic        i_stop,
    output logic [15:0] o_digits,
    output logic        o_running,
    output logic        o_expired,
    output logic        o_done
);

    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_digits, w_digits_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          r_done, w_done_nxt;
    logic          r_running, r_expired;

    logic [15:0]   w_clamped;
    logic [15:0]   w_dec;
    logic          w_is_zero;

    // Clamp each preset digit to its legal BCD range.
    always_comb begin
        w_clamped[15:12] = (i_load_digits[15:12] > 4'd9) ? 4'd9 : i_load_digits[15:12];
        w_clamped[11:8]  = (i_load_digits[11:8]  > 4'd9) ? 4'd9 : i_load_digits[11:8];
        w_clamped[7:4]   = (i_load_digits[7:4]   > 4'd5) ? 4'd5 : i_load_digits[7:4];
        w_clamped[3:0]   = (i_load_digits[3:0]   > 4'd9) ? 4'd9 : i_load_digits[3:0];
    end

    // One-second borrow chain; only consumed when the count is non-zero.
    always_comb begin
        w_dec = r_digits;
        if (r_digits[3:0] != 4'd0) begin
            w_dec[3:0] = r_digits[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_digits[7:4] != 4'd0) begin
                w_dec[7:4] = r_digits[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_digits[11:8] != 4'd0) begin
                    w_dec[11:8] = r_digits[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_digits[15:12] - 4'd1;
                end
            end
        end
    end

    assign w_is_zero = (r_digits == 16'h0000);

    // Next-state logic: Load > Stop > Start > prescaler tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_presc_nxt  = r_presc;
        w_done_nxt   = 1'b0;
        if (i_enable) begin
            if (i_load) begin
                w_digits_nxt = w_clamped;
                w_state_nxt  = S_IDLE;
                w_presc_nxt  = '0;
            end else if (i_stop) begin
                // Stop always blocks Start; prescaler holds so resume finishes the second.
                if (r_state == S_RUN) begin
                    w_state_nxt = S_PAUSE;
                end
            end else if (i_start && (r_state == S_IDLE || r_state == S_PAUSE) && !w_is_zero) begin
                w_state_nxt = S_RUN;
            end else if (r_state == S_RUN) begin
                if (r_presc == P_LAST) begin
                    w_presc_nxt  = '0;
                    w_digits_nxt = w_dec;
                    if (w_dec == 16'h0000) begin
                        w_state_nxt = S_EXPIRED;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_digits  <= 16'h0000;
            r_presc   <= '0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_digits  <= w_digits_nxt;
            r_presc   <= w_presc_nxt;
            r_done    <= w_done_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_expired <= (w_state_nxt == S_EXPIRED);
        end
    end

    assign o_digits  = r_digits;
    assign o_running = r_running;
    assign o_expired = r_expired;
    assign o_done    = r_done;

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// tb_countdown_bcd_timer: directed plus randomized checks of countdown_bcd_timer
// against a seconds-based behavioural model.
module tb_countdown_bcd_timer;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_digits = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] digits;
    logic        running, expired, done;

    countdown_bcd_timer #(.TICKS_PER_SEC(T)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_load       (load),
        .i_load_digits(load_digits),
        .i_start      (start),
        .i_stop       (stop),
        .o_digits     (digits),
        .o_running    (running),
        .o_expired    (expired),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining time in seconds plus a mode and a phase counter.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_secs  = 0;
    int m_mode  = M_IDLE;
    int m_phase = 0;
    bit m_done  = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int preset_secs(input logic [15:0] d);
        int mt, mu, st, su;
        mt = int'(d[15:12]); if (mt > 9) mt = 9;
        mu = int'(d[11:8]);  if (mu > 9) mu = 9;
        st = int'(d[7:4]);   if (st > 5) st = 5;
        su = int'(d[3:0]);   if (su > 9) su = 9;
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step;
        m_done = 0;
        if (!enable) return;
        if (load) begin
            m_secs = preset_secs(load_digits);
            m_mode = M_IDLE;
            m_phase = 0;
        end else if (stop) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs != 0) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_phase == T - 1) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = M_EXP;
                    m_done = 1;
                end
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".digits"},  32'(digits),  32'(secs_to_bcd(m_secs)));
        check({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
        check({tag, ".expired"}, 32'(expired), 32'(m_mode == M_EXP));
        check({tag, ".done"},    32'(done),    32'(m_done));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input string tag, input logic ld, input logic [15:0] d,
                         input logic sa, input logic so);
        load = ld; load_digits = d; start = sa; stop = so;
        step(tag);
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    int done_count;

    initial begin
        // Power-on reset
        #12;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset", 2);

        // Count 00:12 to zero, watch borrow and single done pulse
        drive("ld12", 1, 16'h0012, 0, 0);
        drive("start12", 0, 0, 1, 0);
        done_count = 0;
        for (int i = 0; i < 60; i++) begin
            step("run12");
            if (done) done_count++;
        end
        check("done_pulses", 32'(done_count), 32'd1);
        check("expired_digits", 32'(digits), 32'h0000);
        drive("start_in_exp", 0, 0, 1, 0);
        idle("exp_hold", 5);

        // Minute-level borrows
        drive("ld1000", 1, 16'h1000, 0, 0);
        drive("st1000", 0, 0, 1, 0);
        idle("run1000", T);
        check("borrow_0959", 32'(digits), 32'h0959);
        drive("ld0100", 1, 16'h0100, 0, 0);
        drive("st0100", 0, 0, 1, 0);
        idle("run0100", T);
        check("borrow_0059", 32'(digits), 32'h0059);

        // Pause holds prescaler
        drive("ld0005", 1, 16'h0005, 0, 0);
        drive("st0005", 0, 0, 1, 0);
        idle("run0005", 2);
        drive("stop0005", 0, 0, 0, 1);
        idle("pause", 20);
        check("pause_digits", 32'(digits), 32'h0005);
        drive("resume", 0, 0, 1, 0);
        idle("resume_run", 2);
        check("resume_dec", 32'(digits), 32'h0004);

        // Clamping and zero preset
        drive("ld7F6C", 1, 16'h7F6C, 0, 0);
        check("clamp", 32'(digits), 32'h7959);
        drive("ld0000", 1, 16'h0000, 0, 0);
        drive("st0000", 0, 0, 1, 0);
        idle("zero_idle", 5);

        // Simultaneous controls
        drive("ld0030", 1, 16'h0030, 0, 0);
        drive("startstop", 0, 0, 1, 1);
        idle("ss_idle", 2);
        drive("st0030", 0, 0, 1, 0);
        idle("run0030", 2);
        drive("ld_with_start", 1, 16'h0042, 1, 0);
        check("ld_start_state", 32'(running), 32'd0);
        idle("ld42", 3);

        // Enable low freezes everything
        drive("st0042", 0, 0, 1, 0);
        idle("run0042", 2);
        enable = 1'b0;
        idle("frozen", 10);
        enable = 1'b1;
        idle("thaw", 10);

        // Async reset mid-run at 01:30
        drive("ld0131", 1, 16'h0131, 0, 0);
        drive("st0131", 0, 0, 1, 0);
        idle("run0131", T);
        check("pre_reset", 32'(digits), 32'h0130);
        #2;
        rst_n = 1'b0;
        #1;
        m_secs = 0; m_mode = M_IDLE; m_phase = 0; m_done = 0;
        compare_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("reset_hold", 5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 49) == 0);
            start  = ($urandom_range(0, 19) == 0);
            stop   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 0)
                load_digits = 16'($urandom);
            else
                load_digits = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            step("rand");
        end
        load = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
